// File: rtl/operand_bypass_pkg.sv
// Shared types and default widths for the operand bypass stage.
// No logic here, so there is no latency and no backpressure.
package operand_bypass_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  typedef struct packed {
    logic                      valid;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } hist_entry_t;

  function automatic int hist_entry_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/operand_bypass_lookup.sv
// One-channel priority select: live WB port, then newest-to-oldest history, then RF data.
// Purely combinational (0 cycles); has no flow control of its own.
module bypass_lookup
  import operand_bypass_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 2
) (
  input  logic                        i_wb_en,
  input  logic [ADDR_WIDTH-1:0]       i_wb_addr,
  input  logic [DATA_WIDTH-1:0]       i_wb_data,
  input  logic [DEPTH-1:0]            i_hist_vld,
  input  logic [DEPTH*ADDR_WIDTH-1:0] i_hist_addr,
  input  logic [DEPTH*DATA_WIDTH-1:0] i_hist_data,
  input  logic [ADDR_WIDTH-1:0]       i_rd_addr,
  input  logic [DATA_WIDTH-1:0]       i_rf_data,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic                        o_hit
);

  // Walk oldest to newest so a newer match overwrites an older one.
  always_comb begin
    o_data = i_rf_data;
    o_hit  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (i_hist_vld[k] && (i_hist_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == i_rd_addr)) begin
        o_data = i_hist_data[k*DATA_WIDTH +: DATA_WIDTH];
        o_hit  = 1'b1;
      end
    end
    if (i_wb_en && (i_wb_addr == i_rd_addr)) begin
      o_data = i_wb_data;
      o_hit  = 1'b1;
    end
  end

endmodule

// File: rtl/operand_bypass_unit.sv
// Forwards the newest in-flight writeback onto NUM_READ operand channels; 1-cycle registered latency.
// i_stall freezes history and outputs; i_flush clears them and outranks i_stall; i_reset outranks both.
module operand_bypass_unit
  import operand_bypass_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 2,
  parameter int NUM_READ   = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_stall,
  input  logic                           i_flush,
  input  logic                           i_wb_en,
  input  logic [ADDR_WIDTH-1:0]          i_wb_addr,
  input  logic [DATA_WIDTH-1:0]          i_wb_data,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [NUM_READ*DATA_WIDTH-1:0] i_rf_data,
  output logic [NUM_READ*DATA_WIDTH-1:0] o_operand,
  output logic [NUM_READ-1:0]            o_fwd_hit
);

  logic [DEPTH-1:0]            r_hist_vld;
  logic [DEPTH*ADDR_WIDTH-1:0] r_hist_addr;
  logic [DEPTH*DATA_WIDTH-1:0] r_hist_data;
  logic [NUM_READ*DATA_WIDTH-1:0] r_operand;
  logic [NUM_READ-1:0]            r_fwd_hit;

  logic [NUM_READ*DATA_WIDTH-1:0] w_operand;
  logic [NUM_READ-1:0]            w_fwd_hit;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_ch
    bypass_lookup #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_lookup (
      .i_wb_en     (i_wb_en),
      .i_wb_addr   (i_wb_addr),
      .i_wb_data   (i_wb_data),
      .i_hist_vld  (r_hist_vld),
      .i_hist_addr (r_hist_addr),
      .i_hist_data (r_hist_data),
      .i_rd_addr   (i_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .i_rf_data   (i_rf_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .o_data      (w_operand[i*DATA_WIDTH +: DATA_WIDTH]),
      .o_hit       (w_fwd_hit[i])
    );
  end

  // History addr/data are left unreset; only the valid bits carry meaning after reset or flush.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_hist_vld <= '0;
      r_operand  <= '0;
      r_fwd_hit  <= '0;
    end else if (!i_stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_hist_vld[k]                          <= r_hist_vld[k-1];
        r_hist_addr[k*ADDR_WIDTH +: ADDR_WIDTH] <= r_hist_addr[(k-1)*ADDR_WIDTH +: ADDR_WIDTH];
        r_hist_data[k*DATA_WIDTH +: DATA_WIDTH] <= r_hist_data[(k-1)*DATA_WIDTH +: DATA_WIDTH];
      end
      r_hist_vld[0]                <= i_wb_en;
      r_hist_addr[ADDR_WIDTH-1:0]  <= i_wb_addr;
      r_hist_data[DATA_WIDTH-1:0]  <= i_wb_data;
      r_operand                    <= w_operand;
      r_fwd_hit                    <= w_fwd_hit;
    end
  end

  assign o_operand = r_operand;
  assign o_fwd_hit = r_fwd_hit;

endmodule

// File: doc/operand_bypass_unit.md
# operand_bypass_unit

Parametrised operand-forwarding stage that sits between the register-file read ports and the ALU operand inputs of the pipelined CPU. It generalises the plain pass-through forward path from one fixed 8-bit operand to NUM_READ operand channels of DATA_WIDTH bits. It keeps a DEPTH-entry history of recent register writebacks and substitutes the newest matching writeback value for stale register-file data. Results are registered, so operands reach the ALU one cycle after lookup.

## Interface
- DATA_WIDTH, 8, operand and writeback data width
- ADDR_WIDTH, 3, register address width
- DEPTH, 2, number of writeback history entries (≥1)
- NUM_READ, 2, number of independent operand channels (≥1)

- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- STALL  input  1  hold all state (history and outputs)
- FLUSH  input  1  invalidate history and clear outputs
- WB_EN  input  1  writeback valid this cycle
- WB_ADDR  input  ADDR_WIDTH  writeback destination register
- WB_DATA  input  DATA_WIDTH  writeback value
- RD_ADDR  input  NUM_READ*ADDR_WIDTH  per-channel source register; channel i in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- RF_DATA  input  NUM_READ*DATA_WIDTH  per-channel register-file read data
- OPERAND  output  NUM_READ*DATA_WIDTH  per-channel forwarded operand (registered)
- FWD_HIT  output  NUM_READ  per-channel flag: the registered operand came from a bypass source

## Operation
- History: DEPTH entries of {valid, addr, data}. Entry 0 is newest.
- Each non-stalled, non-flushed edge: entry k receives entry k-1 for k = DEPTH-1 down to 1. Entry 0 receives {WB_EN, WB_ADDR, WB_DATA}. The oldest entry is discarded.
- Per-channel source priority, highest first:
  - the current WB port, when WB_EN is high and WB_ADDR equals RD_ADDR[i]
  - history entry 0 through entry DEPTH-1, first valid address match wins
  - RF_DATA[i]
- The selected value is registered into OPERAND[i]. FWD_HIT[i] is 1 for any non-RF source.
- Lookup uses the history contents from before the current edge's shift.
- Channels are independent. Two channels with the same RD_ADDR receive identical data and identical hit flags.
- A writeback with WB_EN low still shifts the history, with valid=0.
- STALL high: history, OPERAND and FWD_HIT all hold. The WB input is ignored, because the upstream stage holds it.
- FLUSH high, which has priority over STALL:
  - all history valid bits cleared
  - the incoming WB is discarded
  - OPERAND cleared to 0 and FWD_HIT cleared to 0
- RESET has priority over FLUSH and STALL. Every output and every history valid bit goes to 0 at the edge. History addr/data contents do not matter after reset.

## Timing
- Latency is 1 cycle. RD_ADDR, RF_DATA and the WB inputs sampled at edge N appear on OPERAND/FWD_HIT after edge N.
- After reset, OPERAND = 0 and FWD_HIT = 0 until the first non-stalled edge.
- Writeback visibility:
  - at edge N: through the current WB port
  - at edges N+1 … N+DEPTH: through the history
  - from edge N+DEPTH+1: only through RF_DATA, since the register file has committed it by then
- With a stall inserted, the history does not advance during stalled cycles.
- When multiple history entries match, the newest wins. This covers back-to-back writes to the same register.
- Reset or flush asserted mid-stall takes effect on that edge.

## Structure
- Shared package operand_bypass_pkg holds:
  - the history-entry typedef {valid, addr, data}
  - the default DATA_WIDTH/ADDR_WIDTH constants
- Sub-module bypass_lookup: purely combinational priority select for one channel. It takes the WB port, the flattened history and RF_DATA, and returns data and hit.
  - Instantiated NUM_READ times in a generate loop.
- The history shift register and output registers live in the top module.

## Test plan
Use DATA_WIDTH=8, ADDR_WIDTH=3, DEPTH=2, NUM_READ=2 unless stated.
- Reset: hold RESET for 2 edges with random inputs -> OPERAND=0, FWD_HIT=0; then RD_ADDR={3,1} with RF_DATA={0x11,0x22} and no WB -> next cycle OPERAND={0x11,0x22}, FWD_HIT=00.
- Current-port bypass: WB_EN=1, WB_ADDR=5, WB_DATA=0xA5, RD_ADDR ch0=5, RF_DATA ch0=0x00 -> next cycle OPERAND ch0=0xA5, FWD_HIT[0]=1.
- Age-out: write r2=0x3C at edge N, then idle with RF_DATA=0x99 for r2:
  - edges N+1 and N+2 -> OPERAND=0x3C, FWD_HIT=1
  - edge N+3 -> OPERAND=0x99, FWD_HIT=0
- Newest wins: write r4=0x10, then r4=0x20 back-to-back, then read r4 -> 0x20. A simultaneous WB r4=0x30 with the read -> 0x30.
- Stall/flush:
  - history r6=0x77, assert STALL 3 cycles -> outputs frozen; release -> r6 still forwards 0x77
  - history r6=0x77, assert FLUSH -> OPERAND=0, FWD_HIT=0; then read r6 -> RF_DATA value, FWD_HIT=0
- Channel independence: both channels RD_ADDR=7 with WB r7=0xEE -> both channels 0xEE, FWD_HIT=11. Repeat with NUM_READ=3, DEPTH=4, DATA_WIDTH=16.
